// File: rtl/div_share_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | div_share_pkg: shared types/constants for the divider share ctrl. |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package div_share_pkg;

  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] NAN_DEFAULT = 32'h7fc00000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LAUNCH  = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/div_share_ctrl_rr_pick.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | rr_pick: combinational round-robin picker, first set bit at or    |
// | above rr_ptr with wrap at NUM_REQ.                 Rev 1.0        |
// +-------------------------------------------------------------------+
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  int best_off;
  int off;

  // Each requester's distance from the pointer, modulo NUM_REQ; the closest set one wins.
  always_comb begin
    grant    = '0;
    any_req  = 1'b0;
    best_off = NUM_REQ;
    off      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = (i + NUM_REQ - int'(rr_ptr)) % NUM_REQ;
      if (req[i] && (off < best_off)) begin
        best_off = off;
        grant    = IDX_W'(i);
        any_req  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_share_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | div_share_ctrl: round-robin sharing of one multi-cycle divider    |
// | with watchdog abort.                               Rev 1.0        |
// +-------------------------------------------------------------------+
module div_share_ctrl
  import div_share_pkg::*;
#(
  parameter int              NUM_REQ        = 4,
  parameter int              IDX_W          = 2,
  parameter int              TIMEOUT_CYCLES = 255,
  parameter logic [FP_W-1:0] NAN_VALUE      = NAN_DEFAULT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [FP_W*NUM_REQ-1:0] req_a,
  input  logic [FP_W*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [FP_W-1:0]         resp_z,
  output logic                    resp_err,
  output logic                    div_rst,
  output logic [FP_W-1:0]         div_a,
  output logic [FP_W-1:0]         div_b,
  input  logic [FP_W-1:0]         div_z,
  input  logic                    div_z_stb,
  output logic                    busy
);

  localparam int                 TIMER_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0     = NUM_REQ'(1);

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [TIMER_W-1:0] timer;
  logic [IDX_W-1:0]   grant;
  logic               any_req;
  logic [FP_W-1:0]    a_arr [NUM_REQ];
  logic [FP_W-1:0]    b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*FP_W +: FP_W];
    assign b_arr[i] = req_b[i*FP_W +: FP_W];
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req     (req_valid),
    .rr_ptr  (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      rr_ptr     <= '0;
      owner      <= '0;
      timer      <= '0;
      req_ready  <= '0;
      resp_valid <= '0;
      resp_z     <= '0;
      resp_err   <= 1'b0;
      busy       <= 1'b0;
      div_rst    <= 1'b1;
      div_a      <= '0;
      div_b      <= '0;
    end else begin
      req_ready  <= '0;
      resp_valid <= '0;
      case (state)
        ST_IDLE: begin
          div_rst <= 1'b0;
          if (any_req) begin
            owner     <= grant;
            div_a     <= a_arr[grant];
            div_b     <= b_arr[grant];
            req_ready <= ONE_HOT0 << grant;
            div_rst   <= 1'b1;
            busy      <= 1'b1;
            state     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          div_rst <= 1'b0;
          timer   <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          timer <= timer + 1'b1;
          // A strobe on the final watchdog cycle still delivers the real quotient.
          if (div_z_stb) begin
            resp_z     <= div_z;
            resp_err   <= 1'b0;
            resp_valid <= ONE_HOT0 << owner;
            state      <= ST_RESPOND;
          end else if (timer == TIMEOUT_LAST) begin
            resp_z     <= NAN_VALUE;
            resp_err   <= 1'b1;
            resp_valid <= ONE_HOT0 << owner;
            state      <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          rr_ptr   <= (int'(owner) == NUM_REQ - 1) ? '0 : owner + 1'b1;
          resp_err <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_div_share_ctrl.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | tb_div_share_ctrl: randomized self-checking bench with stub div.  |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_div_share_ctrl;

  localparam int         NREQ = 4;
  localparam int         TMO  = 16;
  localparam logic [31:0] NAN = 32'h7fc00000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [NREQ-1:0]   resp_valid;
  logic [31:0]       resp_z;
  logic              resp_err;
  logic              div_rst;
  logic [31:0]       div_a;
  logic [31:0]       div_b;
  logic [31:0]       div_z;
  logic              div_z_stb;
  logic              busy;

  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];

  int vectors = 0;
  int miscompares = 0;
  int model_ptr = 0;

  // Known single-precision quotients used by the stub divider.
  logic [31:0] tab_a [8] = '{32'h3f800000, 32'h40c00000, 32'h41000000, 32'h40400000,
                             32'h3f800000, 32'h41200000, 32'h42c80000, 32'h40000000};
  logic [31:0] tab_b [8] = '{32'h3f800000, 32'h40400000, 32'h40000000, 32'h3f800000,
                             32'h40000000, 32'h40a00000, 32'h41200000, 32'h3f000000};
  logic [31:0] tab_q [8] = '{32'h3f800000, 32'h40000000, 32'h40800000, 32'h40400000,
                             32'h3f000000, 32'h40000000, 32'h41200000, 32'h40800000};

  function automatic logic [31:0] quot(input logic [31:0] a, input logic [31:0] b);
    for (int i = 0; i < 8; i++)
      if (tab_a[i] == a && tab_b[i] == b) return tab_q[i];
    return 32'hdeadbeef;
  endfunction

  assign req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
  assign req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};

  // Stub divider: strobes in the stub_lat-th cycle after div_rst falls (0 = never).
  int stub_lat = 0;
  int stub_cnt = 0;
  bit stub_act = 1'b0;
  always @(posedge clk) begin
    if (div_rst) begin
      stub_cnt <= 0;
      stub_act <= 1'b1;
    end else if (stub_act) begin
      if (div_z_stb) stub_act <= 1'b0;
      stub_cnt <= stub_cnt + 1;
    end
  end
  assign div_z_stb = stub_act && !div_rst && (stub_lat != 0) && (stub_cnt == stub_lat - 1);
  assign div_z     = quot(div_a, div_b);

  div_share_ctrl #(
    .NUM_REQ        (NREQ),
    .IDX_W          (2),
    .TIMEOUT_CYCLES (TMO),
    .NAN_VALUE      (NAN)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_z     (resp_z),
    .resp_err   (resp_err),
    .div_rst    (div_rst),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_z      (div_z),
    .div_z_stb  (div_z_stb),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic int model_pick(input logic [NREQ-1:0] mask);
    for (int off = 0; off < NREQ; off++)
      if (mask[(model_ptr + off) % NREQ]) return (model_ptr + off) % NREQ;
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_resp_valid", 32'(resp_valid), 0);
    chk("rst_resp_z", resp_z, 0);
    chk("rst_resp_err", 32'(resp_err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_div_rst", 32'(div_rst), 1);
    chk("rst_div_a", div_a, 0);
    chk("rst_div_b", div_b, 0);
    rst = 1'b0;
    model_ptr = 0;
    repeat (2) @(negedge clk);
  endtask

  // One full operation; keep=1 leaves every valid bit up after the grant.
  task automatic do_op(input logic [NREQ-1:0] mask, input int lat, input bit keep);
    int g;
    int waits;
    bit seen;
    logic [31:0] exp_z;
    logic [NREQ-1:0] one;
    stub_lat = lat;
    req_valid = mask;
    g = model_pick(mask);
    one = 4'b0001;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      if (req_ready != '0) seen = 1'b1;
    end
    chk("grant_seen", 32'(seen), 1);
    if (!seen) begin
      req_valid = '0;
      return;
    end
    chk("req_ready", 32'(req_ready), 32'(one << g));
    chk("div_a", div_a, op_a[g]);
    chk("div_b", div_b, op_b[g]);
    chk("div_rst_launch", 32'(div_rst), 1);
    if (!keep) req_valid[g] = 1'b0;
    exp_z = (lat >= 1 && lat <= TMO) ? quot(op_a[g], op_b[g]) : NAN;
    waits = 0;
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid != '0) seen = 1'b1;
      else if (busy && !div_rst) waits++;
    end
    chk("resp_seen", 32'(seen), 1);
    chk("resp_valid", 32'(resp_valid), 32'(one << g));
    chk("resp_z", resp_z, exp_z);
    chk("resp_err", 32'(resp_err), (lat >= 1 && lat <= TMO) ? 0 : 1);
    chk("wait_cycles", 32'(waits), (lat >= 1 && lat <= TMO) ? 32'(lat) : 32'(TMO));
    @(negedge clk);
    chk("busy_after", 32'(busy), 0);
    chk("resp_valid_once", 32'(resp_valid), 0);
    model_ptr = (g + 1) % NREQ;
  endtask

  initial begin
    bit got_resp;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = tab_a[i];
      op_b[i] = tab_b[i];
    end
    do_reset();

    op_a[0] = 32'h3f800000; op_b[0] = 32'h3f800000;
    do_op(4'b0001, 7, 1'b0);
    op_a[2] = 32'h40c00000; op_b[2] = 32'h40400000;
    do_op(4'b0100, 4, 1'b0);

    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = tab_a[i + 2];
      op_b[i] = tab_b[i + 2];
    end
    for (int k = 0; k < 5; k++) do_op(4'b1111, 3, 1'b1);
    req_valid = '0;

    do_op(4'b1000, 0, 1'b0);
    do_op(4'b0001, 2, 1'b0);
    do_op(4'b0100, TMO, 1'b0);

    // Reset while requester 1 is waiting on a hung divider.
    stub_lat = 0;
    req_valid = 4'b0010;
    for (int n = 0; n < 50 && req_ready == '0; n++) @(negedge clk);
    req_valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_div_rst", 32'(div_rst), 1);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_resp_valid", 32'(resp_valid), 0);
    rst = 1'b0;
    model_ptr = 0;
    got_resp = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid != '0) got_resp = 1'b1;
    end
    chk("midrst_no_resp", 32'(got_resp), 0);
    do_op(4'b0010, 5, 1'b0);

    for (int k = 0; k < 40; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        int t;
        t = $urandom_range(0, 7);
        op_a[i] = tab_a[t];
        op_b[i] = tab_b[t];
      end
      do_op(4'($urandom_range(1, 15)), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
    end
    req_valid = '0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
